// File: rtl/seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seq_ctrl_pkg
// Shared types and defaults for the SAR ADC conversion sequencer.
//   state_t    : sequencer FSM states
//   *_DEF      : default widths for NBITS / TW / CW
//   phase_len  : maps a programmed phase length of 0 to 1 cycle
// -----------------------------------------------------------------------------
package seq_ctrl_pkg;

    localparam int NBITS_DEF = 12;
    localparam int TW_DEF    = 8;
    localparam int CW_DEF    = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        SAMP  = 3'd2,
        CMP   = 3'd3,
        LOGIC = 3'd4
    } state_t;

    // A phase always lasts at least one cycle, so a zero field means 1.
    function automatic int unsigned phase_len(input int unsigned len);
        return (len == 0) ? 1 : len;
    endfunction

endpackage

// File: rtl/seq_phase_timer.sv
// -----------------------------------------------------------------------------
// seq_phase_timer
// Loadable down-counter that times one sequencer phase.
//   clk, reset_b : clock, async active-low reset
//   load         : (re)start a phase; takes effect at the next edge
//   len          : phase length in cycles, must already be >= 1
//   last         : high during the final cycle of the current phase
// -----------------------------------------------------------------------------
module seq_phase_timer #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          reset_b,
    input  logic          load,
    input  logic [TW-1:0] len,
    output logic          last
);

    logic [TW-1:0] cnt_q;

    // The counter holds the number of cycles remaining after the current one,
    // so a phase of length L counts L-1 down to 0.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            cnt_q <= '0;
        end else if (load) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values, independent of statement order.
            cnt_q <= len - TW'(1);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - TW'(1);
        end
    end

    assign last = (cnt_q == '0);

endmodule

// File: rtl/seq_ctrl.sv
// -----------------------------------------------------------------------------
// seq_ctrl
// Programmable conversion sequencer for the SAR ADC core. Generates the
// INIT / SAMP / CMP / LOGIC strobes and assembles the serial comparator
// decisions into parallel result words.
//   clk, reset_b           : clock, async active-low reset
//   start                  : single-cycle burst request (ignored while busy)
//   abort                  : synchronous stop back to IDLE
//   cfg_t_init/samp/cmp/logic : phase lengths in cycles (0 treated as 1)
//   cfg_n_conv             : conversions per burst, 0 = continuous
//   comp_out               : comparator decision from the core
//   seq_init/samp/cmp/logic: sequencing strobes to the core
//   data_out, data_valid   : last completed result, one-cycle update pulse
//   busy                   : high in every state except IDLE
//   conv_cnt               : conversions completed in the current burst
// -----------------------------------------------------------------------------
module seq_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int NBITS = NBITS_DEF,
    parameter int TW    = TW_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             start,
    input  logic             abort,
    input  logic [TW-1:0]    cfg_t_init,
    input  logic [TW-1:0]    cfg_t_samp,
    input  logic [TW-1:0]    cfg_t_cmp,
    input  logic [TW-1:0]    cfg_t_logic,
    input  logic [CW-1:0]    cfg_n_conv,
    input  logic             comp_out,
    output logic             seq_init,
    output logic             seq_samp,
    output logic             seq_cmp,
    output logic             seq_logic,
    output logic [NBITS-1:0] data_out,
    output logic             data_valid,
    output logic             busy,
    output logic [CW-1:0]    conv_cnt
);

    localparam int            BW      = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [BW-1:0] MSB_IDX = BW'(NBITS - 1);

    state_t           state_q, state_d;
    logic [BW-1:0]    bit_idx_q;
    logic [NBITS-1:0] shift_q;
    logic [NBITS-1:0] data_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_inc;

    // Shadow copies of the configuration, captured on an accepted start.
    logic [TW-1:0]    t_init_q, t_samp_q, t_cmp_q, t_logic_q;
    logic [CW-1:0]    n_conv_q;

    logic             init_q, samp_q, cmp_q, logic_q;
    logic             valid_q, busy_q;

    logic             phase_last;
    logic             timer_load;
    logic [TW-1:0]    len_raw;
    logic [TW-1:0]    timer_len;

    logic             start_acc, cmp_end, logic_end, conv_done, burst_end;

    // -------------------------------------------------------------------------
    // Next-state and phase-timer reload logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        timer_load = 1'b0;
        len_raw    = '0;

        cnt_inc   = cnt_q + CW'(1);
        start_acc = (state_q == IDLE) && start && !abort;
        cmp_end   = (state_q == CMP) && phase_last && !abort;
        logic_end = (state_q == LOGIC) && phase_last && !abort;
        conv_done = logic_end && (bit_idx_q == '0);
        burst_end = conv_done && (n_conv_q != '0) && (cnt_inc == n_conv_q);

        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d    = INIT;
                        timer_load = 1'b1;
                        // Shadows load on this same edge, so use the live value.
                        len_raw    = cfg_t_init;
                    end
                end
                INIT: begin
                    if (phase_last) begin
                        state_d    = SAMP;
                        timer_load = 1'b1;
                        len_raw    = t_samp_q;
                    end
                end
                SAMP: begin
                    if (phase_last) begin
                        state_d    = CMP;
                        timer_load = 1'b1;
                        len_raw    = t_cmp_q;
                    end
                end
                CMP: begin
                    if (phase_last) begin
                        state_d    = LOGIC;
                        timer_load = 1'b1;
                        len_raw    = t_logic_q;
                    end
                end
                LOGIC: begin
                    if (phase_last) begin
                        timer_load = 1'b1;
                        if (bit_idx_q != '0) begin
                            state_d = CMP;
                            len_raw = t_cmp_q;
                        end else if (burst_end) begin
                            state_d = IDLE;
                        end else begin
                            state_d = INIT;
                            len_raw = t_init_q;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        timer_len = TW'(phase_len(32'(len_raw)));
    end

    seq_phase_timer #(
        .TW (TW)
    ) u_timer (
        .clk     (clk),
        .reset_b (reset_b),
        .load    (timer_load),
        .len     (timer_len),
        .last    (phase_last)
    );

    // -------------------------------------------------------------------------
    // FSM state, datapath and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            // NOTE: the shift register is reset like any other flop: its
            // contents reach data_out, so they must never be undefined.
            shift_q   <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            t_init_q  <= '0;
            t_samp_q  <= '0;
            t_cmp_q   <= '0;
            t_logic_q <= '0;
            n_conv_q  <= '0;
            init_q    <= 1'b0;
            samp_q    <= 1'b0;
            cmp_q     <= 1'b0;
            logic_q   <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q <= state_d;

            // Strobes follow the state being entered, so they are flop outputs
            // aligned with state_q.
            init_q  <= (state_d == INIT);
            samp_q  <= (state_d == SAMP);
            cmp_q   <= (state_d == CMP);
            logic_q <= (state_d == LOGIC);
            busy_q  <= (state_d != IDLE);
            valid_q <= 1'b0;

            if (start_acc) begin
                t_init_q  <= cfg_t_init;
                t_samp_q  <= cfg_t_samp;
                t_cmp_q   <= cfg_t_cmp;
                t_logic_q <= cfg_t_logic;
                n_conv_q  <= cfg_n_conv;
                bit_idx_q <= MSB_IDX;
                cnt_q     <= '0;
            end

            if (cmp_end) begin
                shift_q[bit_idx_q] <= comp_out;
            end

            if (logic_end) begin
                if (bit_idx_q != '0) begin
                    bit_idx_q <= bit_idx_q - BW'(1);
                end else begin
                    data_q    <= shift_q;
                    valid_q   <= 1'b1;
                    cnt_q     <= cnt_inc;
                    bit_idx_q <= MSB_IDX;
                end
            end
        end
    end

    assign seq_init   = init_q;
    assign seq_samp   = samp_q;
    assign seq_cmp    = cmp_q;
    assign seq_logic  = logic_q;
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign busy       = busy_q;
    assign conv_cnt   = cnt_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_ctrl
// Self-checking bench for seq_ctrl. Two instances share all inputs:
// dut4 (NBITS=4, CW=4) and dut12 (NBITS=12, CW=16). Inputs change on the
// falling edge; outputs are sampled on the falling edge before driving.
// -----------------------------------------------------------------------------
module tb_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        start, abort, comp_out;
    logic [7:0]  cfg_t_init, cfg_t_samp, cfg_t_cmp, cfg_t_logic;
    logic [15:0] cfg_n_conv;

    wire  [3:0]  strb4, strb12;
    wire         busy4, dv4, busy12, dv12;
    wire  [3:0]  data4, cnt4;
    wire  [11:0] data12;
    wire  [15:0] cnt12;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_ctrl #(.NBITS(4), .TW(8), .CW(4)) dut4 (
        .clk(clk), .reset_b(reset_b), .start(start), .abort(abort),
        .cfg_t_init(cfg_t_init), .cfg_t_samp(cfg_t_samp),
        .cfg_t_cmp(cfg_t_cmp), .cfg_t_logic(cfg_t_logic),
        .cfg_n_conv(cfg_n_conv[3:0]), .comp_out(comp_out),
        .seq_init(strb4[3]), .seq_samp(strb4[2]), .seq_cmp(strb4[1]),
        .seq_logic(strb4[0]), .data_out(data4), .data_valid(dv4),
        .busy(busy4), .conv_cnt(cnt4)
    );

    seq_ctrl #(.NBITS(12), .TW(8), .CW(16)) dut12 (
        .clk(clk), .reset_b(reset_b), .start(start), .abort(abort),
        .cfg_t_init(cfg_t_init), .cfg_t_samp(cfg_t_samp),
        .cfg_t_cmp(cfg_t_cmp), .cfg_t_logic(cfg_t_logic),
        .cfg_n_conv(cfg_n_conv), .comp_out(comp_out),
        .seq_init(strb12[3]), .seq_samp(strb12[2]), .seq_cmp(strb12[1]),
        .seq_logic(strb12[0]), .data_out(data12), .data_valid(dv12),
        .busy(busy12), .conv_cnt(cnt12)
    );

    typedef struct {
        logic       start;
        logic       comp;
        logic [3:0] strb;
        logic       busy;
        logic       dv;
        logic [3:0] data;
        logic [3:0] cnt;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic c, input logic [3:0] st,
                                input logic b, input logic d, input logic [3:0] dt,
                                input logic [3:0] ct);
        vec_t v;
        v.start = s; v.comp = c; v.strb = st; v.busy = b; v.dv = d; v.data = dt; v.cnt = ct;
        return v;
    endfunction

    task automatic set_cfg(input logic [7:0] ti, ts, tc, tl, input logic [15:0] n);
        cfg_t_init = ti; cfg_t_samp = ts; cfg_t_cmp = tc; cfg_t_logic = tl; cfg_n_conv = n;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy4 || busy12) && n < 600) begin
            @(negedge clk);
            n++;
        end
        check(name, {63'd0, busy4 | busy12}, 64'd0);
    endtask

    initial begin
        vec_t        vt[16];
        int          dvs[$];
        int          dv4_at, dv12_at, busy_cyc, excl_err, cnt_err, dvn, wrap_val, bi;
        logic [3:0]  zl_exp[5];
        logic [3:0]  pat4;
        logic [11:0] pat12;

        reset_b = 1'b0; start = 1'b0; abort = 1'b0; comp_out = 1'b0;
        set_cfg(8'd2, 8'd3, 8'd1, 8'd1, 16'd1);
        repeat (2) @(negedge clk);
        check("reset4",  {50'd0, strb4, busy4, dv4, data4, cnt4}, 64'd0);
        check("reset12", {30'd0, strb12, busy12, dv12, data12, cnt12}, 64'd0);
        reset_b = 1'b1;

        // ---- single 4-bit conversion, cycle by cycle ----
        vt[0]  = mk(1, 0, 4'b0000, 0, 0, 4'h0, 4'd0);
        vt[1]  = mk(0, 0, 4'b1000, 1, 0, 4'h0, 4'd0);
        vt[2]  = mk(0, 0, 4'b1000, 1, 0, 4'h0, 4'd0);
        vt[3]  = mk(0, 0, 4'b0100, 1, 0, 4'h0, 4'd0);
        vt[4]  = mk(0, 0, 4'b0100, 1, 0, 4'h0, 4'd0);
        vt[5]  = mk(0, 0, 4'b0100, 1, 0, 4'h0, 4'd0);
        vt[6]  = mk(0, 1, 4'b0010, 1, 0, 4'h0, 4'd0);
        vt[7]  = mk(0, 0, 4'b0001, 1, 0, 4'h0, 4'd0);
        vt[8]  = mk(0, 0, 4'b0010, 1, 0, 4'h0, 4'd0);
        vt[9]  = mk(0, 0, 4'b0001, 1, 0, 4'h0, 4'd0);
        vt[10] = mk(0, 1, 4'b0010, 1, 0, 4'h0, 4'd0);
        vt[11] = mk(0, 0, 4'b0001, 1, 0, 4'h0, 4'd0);
        vt[12] = mk(0, 1, 4'b0010, 1, 0, 4'h0, 4'd0);
        vt[13] = mk(0, 0, 4'b0001, 1, 0, 4'h0, 4'd0);
        vt[14] = mk(0, 0, 4'b0000, 0, 1, 4'hB, 4'd1);
        vt[15] = mk(0, 0, 4'b0000, 0, 0, 4'hB, 4'd1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check($sformatf("conv4[%0d]", i), {50'd0, strb4, busy4, dv4, data4, cnt4},
                  {50'd0, vt[i].strb, vt[i].busy, vt[i].dv, vt[i].data, vt[i].cnt});
            start = vt[i].start;
            comp_out = vt[i].comp;
        end
        wait_idle("idle_after_conv4");

        // ---- zero-length fields: every phase lasts one cycle ----
        set_cfg(8'd0, 8'd0, 8'd0, 8'd0, 16'd1);
        comp_out = 1'b1;
        zl_exp[0] = 4'b1000; zl_exp[1] = 4'b0100; zl_exp[2] = 4'b0010;
        zl_exp[3] = 4'b0001; zl_exp[4] = 4'b0010;
        dv4_at = -1; dv12_at = -1;
        @(negedge clk);
        start = 1'b1;
        for (int m = 1; m <= 40; m++) begin
            @(negedge clk);
            start = 1'b0;
            if (m <= 5) check($sformatf("zl_strb_m%0d", m), {60'd0, strb12}, {60'd0, zl_exp[m-1]});
            if (dv4 && dv4_at < 0) dv4_at = m;
            if (dv12 && dv12_at < 0) dv12_at = m;
        end
        check("zl_period12", 64'(dv12_at), 64'(27));
        check("zl_period4", 64'(dv4_at), 64'(11));
        check("zl_data12", {52'd0, data12}, 64'hFFF);
        check("zl_data4", {60'd0, data4}, 64'hF);
        wait_idle("idle_after_zl");

        // ---- finite burst of 3 ----
        set_cfg(8'd2, 8'd3, 8'd1, 8'd1, 16'd3);
        comp_out = 1'b0;
        busy_cyc = 0; excl_err = 0;
        @(negedge clk);
        start = 1'b1;
        for (int m = 1; m <= 45; m++) begin
            @(negedge clk);
            start = 1'b0;
            if (dv4) dvs.push_back(m);
            if (busy4) busy_cyc++;
            if ($countones(strb4) != (busy4 ? 1 : 0)) excl_err++;
        end
        check("burst_dv_count", 64'(dvs.size()), 64'(3));
        for (int k = 0; k < 3; k++)
            check($sformatf("burst_dv%0d_at", k), 64'((k < dvs.size()) ? dvs[k] : -1), 64'(14 + 13*k));
        check("burst_busy_cycles", 64'(busy_cyc), 64'(39));
        check("burst_strobe_excl", 64'(excl_err), 64'd0);
        check("burst_cnt", {60'd0, cnt4}, 64'd3);
        check("burst_data", {60'd0, data4}, 64'd0);
        wait_idle("idle_after_burst");

        // ---- start while busy and mid-burst config change are ignored ----
        set_cfg(8'd2, 8'd3, 8'd1, 8'd1, 16'd1);
        pat4 = 4'b0110; bi = 3; dv4_at = -1; dvn = 0;
        @(negedge clk);
        start = 1'b1;
        for (int m = 1; m <= 20; m++) begin
            @(negedge clk);
            start = (m == 4);
            if (m == 4) cfg_t_samp = 8'd7;
            if (strb4[1] && bi >= 0) begin comp_out = pat4[bi]; bi--; end
            if (dv4) begin dvn++; if (dv4_at < 0) dv4_at = m; end
            if (m == 16) check("sb_busy_after", {63'd0, busy4}, 64'd0);
        end
        check("sb_dv_at", 64'(dv4_at), 64'(14));
        check("sb_dv_count", 64'(dvn), 64'(1));
        check("sb_data", {60'd0, data4}, 64'h6);
        wait_idle("idle_after_sb");

        // ---- continuous mode with counter wrap, then abort ----
        set_cfg(8'd0, 8'd0, 8'd0, 8'd0, 16'd0);
        comp_out = 1'b1;
        dvn = 0; cnt_err = 0; wrap_val = -1;
        @(negedge clk);
        start = 1'b1;
        for (int m = 1; m <= 400 && dvn < 17; m++) begin
            @(negedge clk);
            start = 1'b0;
            if (dv4) begin
                dvn++;
                if (int'(cnt4) != dvn % 16) cnt_err++;
                if (dvn == 16) wrap_val = int'(cnt4);
            end
        end
        check("cont_dv_count", 64'(dvn), 64'(17));
        check("cont_cnt_seq", 64'(cnt_err), 64'd0);
        check("cont_wrap", 64'(wrap_val), 64'd0);
        repeat (3) @(negedge clk);
        check("cont_still_busy", {63'd0, busy4}, 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_out4", {56'd0, strb4, busy4, dv4, cnt4}, {56'd0, 4'b0000, 1'b0, 1'b0, 4'd1});
        check("abort_out12", {58'd0, strb12, busy12, dv12}, 64'd0);
        check("abort_data4", {60'd0, data4}, 64'hF);
        dvn = 0;
        repeat (4) begin @(negedge clk); if (dv4 || busy4) dvn++; end
        check("abort_stays_idle", 64'(dvn), 64'd0);

        // ---- abort has priority over start in IDLE ----
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_vs_start", {62'd0, busy4, busy12}, 64'd0);
        @(negedge clk);
        check("abort_vs_start_late", {62'd0, busy4, busy12}, 64'd0);

        // ---- abort during the 5th bit of a 12-bit conversion ----
        set_cfg(8'd2, 8'd3, 8'd1, 8'd1, 16'd1);
        comp_out = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int m = 1; m <= 14; m++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("amid_in_cmp", {60'd0, strb12}, 64'b0010);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("amid_strobes", {59'd0, strb12, busy12}, 64'd0);
        dvn = 0;
        repeat (5) begin @(negedge clk); if (dv12) dvn++; end
        check("amid_no_dv", 64'(dvn), 64'd0);
        check("amid_data_kept", {52'd0, data12}, 64'hFFF);
        wait_idle("idle_after_amid");

        // ---- clean conversion after the abort ----
        pat12 = 12'hA5C; bi = 11; dv12_at = -1;
        @(negedge clk);
        start = 1'b1;
        for (int m = 1; m <= 35; m++) begin
            @(negedge clk);
            start = 1'b0;
            if (strb12[1] && bi >= 0) begin comp_out = pat12[bi]; bi--; end
            if (dv12 && dv12_at < 0) dv12_at = m;
        end
        check("post_abort_dv_at", 64'(dv12_at), 64'(30));
        check("post_abort_data", {52'd0, data12}, 64'hA5C);
        check("post_abort_cnt", {48'd0, cnt12}, 64'd1);
        wait_idle("idle_after_clean");

        // ---- asynchronous reset in the middle of SAMP ----
        @(negedge clk);
        start = 1'b1;
        for (int m = 1; m <= 4; m++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("rst_in_samp", {60'd0, strb12}, 64'b0100);
        reset_b = 1'b0;
        #1;
        check("rst_mid4",  {50'd0, strb4, busy4, dv4, data4, cnt4}, 64'd0);
        check("rst_mid12", {30'd0, strb12, busy12, dv12, data12, cnt12}, 64'd0);
        @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);
        check("rst_release", {60'd0, strb12}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
